// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared definitions for the iterative multiply/divide unit:
//                operation encodings, FSM state type, default operand width
//                and small op-decoding helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  // Operation encodings carried on req_op
  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  // Bit 1 of the op selects divide, bit 0 selects the unsigned flavour.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_if
//  Description : Execute-stage <-> MDU bundle: request handshake, flush,
//                completion pulse and the HI/LO read/write path.
//  Ports       : master = execute stage, slave = mdu
//                req_valid/req_ready/req_op/src_a/src_b : request handshake
//                flush                                   : abandon operation
//                resp_valid                              : completion pulse
//                hi_we/lo_we/hilo_wdata                  : MTHI/MTLO
//                hi/lo                                   : MFHI/MFLO
//  Revision    : 1.0 - initial release
// ============================================================================
interface mdu_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) ();

  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             resp_valid;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] hilo_wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output req_valid, req_op, src_a, src_b, flush, hi_we, lo_we, hilo_wdata,
    input  req_ready, resp_valid, hi, lo
  );

  modport slave (
    input  req_valid, req_op, src_a, src_b, flush, hi_we, lo_we, hilo_wdata,
    output req_ready, resp_valid, hi, lo
  );

endinterface
`default_nettype wire

// File: rtl/mdu_div_core.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_div_core
//  Description : One restoring-division step. Takes the shifted partial
//                remainder {rem, next dividend bit} and the divisor, returns
//                the next remainder and the quotient bit.
//  Ports       : i_part    [WIDTH:0]   shifted partial remainder
//                i_divisor [WIDTH-1:0] divisor magnitude
//                o_rem     [WIDTH-1:0] next partial remainder
//                o_qbit                quotient bit for this step
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_div_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH:0]   i_part,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_diff;

  // The running remainder is always below the divisor, so i_part is below
  // twice the divisor and the difference fits in WIDTH+1 signed bits: its
  // top bit is the borrow. (A zero divisor breaks this, but the caller
  // overrides that result.)
  assign w_diff = i_part - {1'b0, i_divisor};
  assign o_qbit = ~w_diff[WIDTH];
  assign o_rem  = o_qbit ? w_diff[WIDTH-1:0] : i_part[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
//  Module      : mdu
//  Description : Iterative multiply/divide unit owning HI/LO. Radix-2
//                shift-add multiply and restoring divide on operand
//                magnitudes, one bit per cycle, followed by a sign-fix cycle
//                and a one-cycle completion pulse.
//  Ports       : clk    - clock, rising edge
//                resetn - asynchronous active-low reset
//                bus    - mdu_if.slave (request, flush, response, HI/LO)
//  Config      : MDU_FAST_MUL_EN - single-cycle multiplier for MULT/MULTU
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic clk,
  input  logic resetn,
  mdu_if.slave bus
);

  localparam int               CNT_W  = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_ITER = CNT_W'(WIDTH);

  mdu_state_e r_state;
  mdu_state_e w_state_nxt;

  logic                 r_is_div;
  logic                 r_neg_q;    // product / quotient must be negated
  logic                 r_neg_r;    // remainder must be negated
  logic                 r_div0;
  logic [WIDTH-1:0]     r_a;        // multiplicand, or dividend shifting out
  logic [WIDTH-1:0]     r_b;        // multiplier shifting out, or divisor
  logic [WIDTH-1:0]     r_src_a;    // raw dividend for the divide-by-zero case
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_accept;
  logic                 w_signed;
  logic                 w_is_div;
  logic                 w_fast;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [WIDTH:0]       w_mul_sum;
  logic [WIDTH:0]       w_div_part;
  logic [WIDTH-1:0]     w_div_rem;
  logic                 w_div_qbit;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo_mag;
  logic [WIDTH-1:0]     w_rem_mag;
  logic [WIDTH-1:0]     w_res_hi;
  logic [WIDTH-1:0]     w_res_lo;
  logic                 w_done_wr;

  // ---------------------------------------------------------------- request
  assign w_accept = bus.req_valid & (r_state == ST_IDLE) & ~bus.flush;
  assign w_signed = op_is_signed(bus.req_op);
  assign w_is_div = op_is_div(bus.req_op);
  assign w_abs_a  = (w_signed & bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
  assign w_abs_b  = (w_signed & bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_prod;
  assign w_fast      = ~w_is_div;
  assign w_fast_prod = {{WIDTH{1'b0}}, w_abs_a} * {{WIDTH{1'b0}}, w_abs_b};
`else
  assign w_fast = 1'b0;
`endif

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.req_valid) w_state_nxt = ST_BUSY;
        ST_BUSY: if (r_cnt == '0)   w_state_nxt = ST_FIX;
        ST_FIX:                     w_state_nxt = ST_DONE;
        ST_DONE:                    w_state_nxt = ST_IDLE;
        default:                    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------- datapath
  // Multiply: add the multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right by one.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + {1'b0, (r_b[0] ? r_a : {WIDTH{1'b0}})};

  // Divide: upper half holds the remainder, lower half collects quotient
  // bits; dividend bits are fed in MSB first from r_a.
  assign w_div_part = {r_acc[2*WIDTH-1:WIDTH], r_a[WIDTH-1]};

  mdu_div_core #(.WIDTH(WIDTH)) u_div_core (
    .i_part    (w_div_part),
    .i_divisor (r_b),
    .o_rem     (w_div_rem),
    .o_qbit    (w_div_qbit)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_src_a  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_is_div <= w_is_div;
      r_neg_q  <= w_signed & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
      r_neg_r  <= w_signed & bus.src_a[WIDTH-1];
      r_div0   <= w_is_div & (bus.src_b == '0);
      r_a      <= w_abs_a;
      r_b      <= w_abs_b;
      r_src_a  <= bus.src_a;
`ifdef MDU_FAST_MUL_EN
      r_acc    <= w_fast ? w_fast_prod : '0;
`else
      r_acc    <= '0;
`endif
      // A zero count sends BUSY straight to FIX on the next edge.
      r_cnt    <= w_fast ? '0 : C_ITER;
    end else if ((r_state == ST_BUSY) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_is_div) begin
        r_acc <= {w_div_rem, r_acc[WIDTH-2:0], w_div_qbit};
        r_a   <= {r_a[WIDTH-2:0], 1'b0};
      end else begin
        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
        r_b   <= {1'b0, r_b[WIDTH-1:1]};
      end
    end
  end

  // -------------------------------------------------------- sign correction
  // Evaluated while in FIX and captured into HI/LO on the FIX->DONE edge.
  // 0x80000000 / -1 needs no special case: |a| / 1 = 0x80000000, the signs
  // agree, and the remainder is zero.
  assign w_prod    = r_neg_q ? -r_acc : r_acc;
  assign w_quo_mag = r_acc[WIDTH-1:0];
  assign w_rem_mag = r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_div0) begin
        w_res_hi = r_src_a;
        w_res_lo = '1;
      end else begin
        w_res_hi = r_neg_r ? -w_rem_mag : w_rem_mag;
        w_res_lo = r_neg_q ? -w_quo_mag : w_quo_mag;
      end
    end
  end

  // ------------------------------------------------------------------ HI/LO
  assign w_done_wr = (r_state == ST_FIX) & ~bus.flush;

  // A completing result takes both registers and beats any MTHI/MTLO.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done_wr) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end else begin
      if (bus.hi_we) r_hi <= bus.hilo_wdata;
      if (bus.lo_we) r_lo <= bus.hilo_wdata;
    end
  end

  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.resp_valid = (r_state == ST_DONE);
  assign bus.hi         = r_hi;
  assign bus.lo         = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu
//  Description : Self-checking bench for mdu. Table of directed vectors plus
//                random vectors checked against a behavioural model through
//                a response scoreboard, followed by hand-written sequences
//                for flush, MTHI/MTLO races and mid-operation reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu;
  import mdu_pkg::*;

  localparam int W = 32;
  // Negedges after the accept edge at which resp_valid is first seen.
  localparam int DIV_LAT = W + 3;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = W + 3;
`endif

  typedef struct {
    logic [63:0] exp;   // {hi, lo}
    string       name;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];
  vec_t vecs[12];
  logic [1:0]  rop;
  logic [31:0] ra;
  logic [31:0] rb;

  mdu_if #(.WIDTH(W)) bus ();

  mdu #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (op)
      MDU_MULT:  res = 64'(sa * sb);
      MDU_MULTU: res = {32'd0, a} * {32'd0, b};
      MDU_DIV: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else            res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  // Scoreboard: compare HI/LO on every completion pulse.
  always @(negedge clk) begin : mon
    exp_t e;
    if (resetn && bus.resp_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_resp: resp_valid with nothing outstanding, hi=0x%0h lo=0x%0h",
                 bus.hi, bus.lo);
      end else begin
        e = sb_q.pop_front();
        chk({e.name, "_hi"}, {32'd0, bus.hi}, {32'd0, e.exp[63:32]});
        chk({e.name, "_lo"}, {32'd0, bus.lo}, {32'd0, e.exp[31:0]});
      end
    end
  end

  // Called at a negedge; returns at the first negedge after the accept edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit push, input logic [63:0] exp, input string name);
    exp_t e;
    chk({name, "_ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.src_a     = a;
    bus.src_b     = b;
    if (push) begin
      e.exp  = exp;
      e.name = name;
      sb_q.push_back(e);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string name);
    int k;
    start_op(op, a, b, 1'b1, exp, name);
    k = 1;
    chk({name, "_busy"}, 64'(bus.req_ready), 64'd0);
    while (!bus.resp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_latency"}, 64'(k), 64'(op[1] ? DIV_LAT : MUL_LAT));
    if (!bus.resp_valid && sb_q.size() != 0) void'(sb_q.pop_front());
    @(negedge clk);
    chk({name, "_pulse"}, 64'(bus.resp_valid), 64'd0);
    chk({name, "_ready_after"}, 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    resetn         = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.src_a      = '0;
    bus.src_b      = '0;
    bus.flush      = 1'b0;
    bus.hi_we      = 1'b0;
    bus.lo_we      = 1'b0;
    bus.hilo_wdata = '0;

    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(bus.req_ready), 64'd1);
    chk("reset_resp",  64'(bus.resp_valid), 64'd0);
    chk("reset_hi",    {32'd0, bus.hi}, 64'd0);
    chk("reset_lo",    {32'd0, bus.lo}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // ---------------- directed vectors: {op, a, b, {hi, lo}}
    vecs[0]  = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}};
    vecs[1]  = '{MDU_MULT,  32'hFFFF_FFFD, 32'd7,         {32'hFFFF_FFFF, 32'hFFFF_FFEB}};
    vecs[2]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
    vecs[3]  = '{MDU_DIVU,  32'd100,       32'd0,         {32'd100,       32'hFFFF_FFFF}};
    vecs[4]  = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'd0,         32'h8000_0000}};
    vecs[5]  = '{MDU_DIVU,  32'd9,         32'd2,         {32'd1,         32'd4}};
    vecs[6]  = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'd0}};
    vecs[7]  = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, {32'd1,         32'hFFFF_FFFD}};
    vecs[8]  = '{MDU_DIV,   32'hFFFF_FFFB, 32'd0,         {32'hFFFF_FFFB, 32'hFFFF_FFFF}};
    vecs[9]  = '{MDU_DIVU,  32'hFFFF_FFFF, 32'd1,         {32'd0,         32'hFFFF_FFFF}};
    vecs[10] = '{MDU_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'd0,         32'd1}};
    vecs[11] = '{MDU_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, {32'hFFFF_FFFE, 32'd2}};

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    // ---------------- random vectors against the model
    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      run_op(rop, ra, rb, model(rop, ra, rb), $sformatf("rand%0d", i));
    end

    // ---------------- flush mid-operation
    bus.hi_we = 1'b1; bus.hilo_wdata = 32'hAAAA_0001;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.hilo_wdata = 32'h5555_0002;
    @(negedge clk);
    bus.lo_we = 1'b0;
    chk("mt_hi", {32'd0, bus.hi}, 64'h0000_0000_AAAA_0001);
    chk("mt_lo", {32'd0, bus.lo}, 64'h0000_0000_5555_0002);
    start_op(MDU_DIVU, 32'd9, 32'd2, 1'b0, 64'd0, "flush_op");
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_ready", 64'(bus.req_ready), 64'd1);
    repeat (40) @(negedge clk);
    chk("flush_hi_kept", {32'd0, bus.hi}, 64'h0000_0000_AAAA_0001);
    chk("flush_lo_kept", {32'd0, bus.lo}, 64'h0000_0000_5555_0002);
    run_op(MDU_DIVU, 32'd9, 32'd2, {32'd1, 32'd4}, "after_flush");

    // ---------------- flush in IDLE discards a same-cycle request
    bus.req_valid = 1'b1; bus.req_op = MDU_MULTU; bus.src_a = 32'd3; bus.src_b = 32'd3;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.flush = 1'b0;
    chk("flush_accept_ready", 64'(bus.req_ready), 64'd1);
    repeat (40) @(negedge clk);

    // ---------------- MTHI while busy, MTLO on the completion edge
    start_op(MDU_DIVU, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14}, "mt_race");
    repeat (4) @(negedge clk);
    bus.hi_we = 1'b1; bus.hilo_wdata = 32'h0000_1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    chk("mthi_busy", {32'd0, bus.hi}, 64'h0000_0000_0000_1234);
    repeat (28) @(negedge clk);
    bus.lo_we = 1'b1; bus.hilo_wdata = 32'h0000_DEAD;
    @(negedge clk);
    bus.lo_we = 1'b0;
    chk("mt_race_resp", 64'(bus.resp_valid), 64'd1);
    @(negedge clk);
    chk("mt_race_lo_kept", {32'd0, bus.lo}, 64'd14);

    // ---------------- reset in the middle of an operation
    start_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 64'd0, "rst_op");
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_resp",  64'(bus.resp_valid), 64'd0);
    chk("rst_hi",    {32'd0, bus.hi}, 64'd0);
    chk("rst_lo",    {32'd0, bus.lo}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_no_write_hi", {32'd0, bus.hi}, 64'd0);
    chk("rst_no_write_lo", {32'd0, bus.lo}, 64'd0);
    run_op(MDU_MULTU, 32'd5, 32'd6, {32'd0, 32'd30}, "post_rst_multu");

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
